// File: rtl/main_func_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : main_func_mul_pkg (package)
//  Description : Shared types and constant functions for main_func_mul_pipe.
//                Internally every operand is carried sign-extended to
//                C_OPND_W bits and every product to C_PROD_W bits. This
//                bounds din*_WIDTH to 31 and dout_WIDTH to 63.
//  Contents    : C_OPND_W, C_PROD_W, prod_t, mul_slot_t,
//                prod_width(), r_max(), r_min()
//  Revision    : 1.0 - initial release
// ============================================================================
package main_func_mul_pkg;

    localparam int unsigned C_OPND_W = 32;
    localparam int unsigned C_PROD_W = 64;

    typedef logic signed [C_PROD_W-1:0] prod_t;

    // One pipeline slot. The operand slot packs {op0, op1}; product slots
    // hold P sign-extended to C_PROD_W.
    typedef struct packed {
        logic                valid;
        logic [C_PROD_W-1:0] data;
        logic                ovf;
    } mul_slot_t;

    // Width of the exact product of the two 1-bit-extended operands.
    function automatic int unsigned prod_width(input int unsigned w0,
                                               input int unsigned w1);
        return w0 + w1 + 1;
    endfunction

    // Largest value representable in w bits of the given signedness.
    function automatic prod_t r_max(input int unsigned w, input bit is_signed);
        if (is_signed) begin
            return (prod_t'(1) <<< (w - 1)) - prod_t'(1);
        end
        return (prod_t'(1) <<< w) - prod_t'(1);
    endfunction

    // Smallest value representable in w bits of the given signedness.
    function automatic prod_t r_min(input int unsigned w, input bit is_signed);
        if (is_signed) begin
            return -(prod_t'(1) <<< (w - 1));
        end
        return '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/main_func_mul_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : main_func_mul_pipe_if (interface)
//  Description : Operand/result handshake bundle of main_func_mul_pipe.
//  Signals     : in_valid/in_ready/din0/din1   - operand channel
//                out_valid/out_ready/dout/out_ovf - result channel
//  Modports    : master - producer of operands / consumer of results
//                slave  - the multiplier
//  Revision    : 1.0 - initial release
// ============================================================================
interface main_func_mul_pipe_if #(
    parameter int din0_WIDTH = 6,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 13
);
    logic                  in_valid;
    logic                  in_ready;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [dout_WIDTH-1:0] dout;
    logic                  out_ovf;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, dout, out_ovf
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, dout, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/main_func_mul_pipe_narrow.sv
`default_nettype none
// ============================================================================
//  Module      : main_func_mul_pipe_narrow
//  Description : Combinational narrowing of the exact product to DOUT_W bits
//                plus out-of-range detection. Wraps by default; clamps to
//                the range limits when MAIN_FUNC_MUL_PIPE_SAT_EN is defined.
//  Ports       : p_i    in  C_PROD_W  exact product, sign-extended
//                dout_o out DOUT_W    narrowed result
//                ovf_o  out 1         p_i outside the DOUT_W range
//  Macro       : MAIN_FUNC_MUL_PIPE_SAT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module main_func_mul_pipe_narrow
    import main_func_mul_pkg::*;
#(
    parameter int DOUT_W     = 13,
    parameter bit RES_SIGNED = 1'b0
) (
    input  prod_t             p_i,
    output logic [DOUT_W-1:0] dout_o,
    output logic              ovf_o
);

    localparam prod_t C_R_MAX = r_max(DOUT_W, RES_SIGNED);
    localparam prod_t C_R_MIN = r_min(DOUT_W, RES_SIGNED);

    logic w_above;
    logic w_below;

    assign w_above = (p_i > C_R_MAX);
    assign w_below = (p_i < C_R_MIN);
    assign ovf_o   = w_above | w_below;

`ifdef MAIN_FUNC_MUL_PIPE_SAT_EN
    always_comb begin
        dout_o = p_i[DOUT_W-1:0];
        if (w_above) begin
            dout_o = C_R_MAX[DOUT_W-1:0];
        end else if (w_below) begin
            dout_o = C_R_MIN[DOUT_W-1:0];
        end
    end
`else
    assign dout_o = p_i[DOUT_W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/main_func_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : main_func_mul_pipe
//  Description : Parametrised pipelined integer multiplier with valid/ready
//                flow control, per-operand signedness and overflow flag.
//                A single global advance (adv = !out_valid || out_ready)
//                shifts every slot; bubbles are kept, never collapsed.
//                Slot layout for NUM_STAGE >= 2:
//                  slot 1        extended operands
//                  slot 2..N-1   product P (delay line)
//                  slot N        narrowed result + ovf
//                NUM_STAGE = 1 computes everything into the single slot.
//  Ports       : clk    in  1  rising-edge clock
//                reset  in  1  asynchronous active-high reset
//                bus    slave modport of main_func_mul_pipe_if
//  Limits      : din0_WIDTH, din1_WIDTH <= 31; dout_WIDTH <= 63;
//                NUM_STAGE 1..8
//  Macro       : MAIN_FUNC_MUL_PIPE_SAT_EN (saturating narrowing)
//  Revision    : 1.0 - initial release
// ============================================================================
module main_func_mul_pipe
    import main_func_mul_pkg::*;
#(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int din0_WIDTH  = 6,
    parameter int din1_WIDTH  = 8,
    parameter int dout_WIDTH  = 13,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    main_func_mul_pipe_if.slave  bus
);

    localparam bit C_RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

    logic                     w_adv;
    logic                     w_msb0;
    logic                     w_msb1;
    logic signed [C_OPND_W-1:0] w_a_ext;
    logic signed [C_OPND_W-1:0] w_b_ext;

    prod_t                    narrow_p_d;
    logic                     valid_d;
    logic [dout_WIDTH-1:0]    dout_d;
    logic                     ovf_d;

    logic                     out_valid_q;
    logic [dout_WIDTH-1:0]    dout_q;
    logic                     ovf_q;

    logic [31:0]              unused_id;
    assign unused_id = 32'(ID);

    // Backpressure is global: a held result freezes every slot.
    assign w_adv        = !out_valid_q || bus.out_ready;
    assign bus.in_ready = w_adv;

    // Extension to C_OPND_W: sign bit for signed operands, zero otherwise.
    // Multiplying the extended values as signed gives the exact product.
    assign w_msb0  = (DIN0_SIGNED != 0) ? bus.din0[din0_WIDTH-1] : 1'b0;
    assign w_msb1  = (DIN1_SIGNED != 0) ? bus.din1[din1_WIDTH-1] : 1'b0;
    assign w_a_ext = {{(C_OPND_W-din0_WIDTH){w_msb0}}, bus.din0};
    assign w_b_ext = {{(C_OPND_W-din1_WIDTH){w_msb1}}, bus.din1};

    generate
        if (NUM_STAGE == 1) begin : g_single
            assign narrow_p_d = prod_t'(w_a_ext) * prod_t'(w_b_ext);
            assign valid_d    = bus.in_valid;
        end else begin : g_multi
            mul_slot_t ops_q;
            prod_t     w_p;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ops_q <= '0;
                end else if (w_adv) begin
                    ops_q.valid <= bus.in_valid;
                    ops_q.data  <= {w_a_ext, w_b_ext};
                    ops_q.ovf   <= 1'b0;
                end
            end

            assign w_p = prod_t'($signed(ops_q.data[C_PROD_W-1:C_OPND_W]))
                       * prod_t'($signed(ops_q.data[C_OPND_W-1:0]));

            if (NUM_STAGE == 2) begin : g_no_delay
                logic unused_ovf;
                assign unused_ovf = ops_q.ovf;
                assign narrow_p_d = w_p;
                assign valid_d    = ops_q.valid;
            end else begin : g_delay
                mul_slot_t prod_q [NUM_STAGE-2];
                logic      unused_ovf;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        for (int i = 0; i < NUM_STAGE-2; i++) begin
                            prod_q[i] <= '0;
                        end
                    end else if (w_adv) begin
                        prod_q[0].valid <= ops_q.valid;
                        prod_q[0].data  <= w_p;
                        prod_q[0].ovf   <= 1'b0;
                        for (int i = 1; i < NUM_STAGE-2; i++) begin
                            prod_q[i] <= prod_q[i-1];
                        end
                    end
                end

                assign unused_ovf = ops_q.ovf ^ prod_q[NUM_STAGE-3].ovf;
                assign narrow_p_d = prod_q[NUM_STAGE-3].data;
                assign valid_d    = prod_q[NUM_STAGE-3].valid;
            end
        end
    endgenerate

    main_func_mul_pipe_narrow #(
        .DOUT_W     (dout_WIDTH),
        .RES_SIGNED (C_RES_SIGNED)
    ) u_narrow (
        .p_i    (narrow_p_d),
        .dout_o (dout_d),
        .ovf_o  (ovf_d)
    );

    // Last slot: registered result, overflow flag and valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (w_adv) begin
            out_valid_q <= valid_d;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.out_ovf   = ovf_q;

endmodule
`default_nettype wire
